seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a NUM_DIGITS common-anode/cathode 7-segment display that shares a single BCD-to-7-segment decoder across all digits. It holds a double-buffered display value, sequences one digit at a time onto the shared decoder input, and drives one-hot digit enables with an inter-digit blanking gap to suppress ghosting. It sits between the counter/ALU datapath that produces BCD values and the decoder/pin outputs.

## Interface
- NUM_DIGITS, 4, number of scanned digits (2..8)
- DIGIT_CYCLES, 50000, clk cycles each digit is lit (>=1)
- GAP_CYCLES, 500, clk cycles all digits dark between digits (>=1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  one-cycle request: capture din into shadow buffer
- din  in  4*NUM_DIGITS  BCD value, digit 0 in bits [3:0] (least significant)
- lzb_en  in  1  leading-zero blanking enable, sampled continuously
- bcd  out  4  nibble to shared decoder, registered
- an  out  NUM_DIGITS  one-hot active-high digit enable, registered
- frame_start  out  1  one-cycle pulse in the first lit cycle of digit 0
- load_ack  out  1  one-cycle pulse when shadow value becomes displayed
- pending  out  1  shadow holds a value not yet displayed

## Operation
- Registers: shadow[4N], active[4N], pending, idx, cycle counter, state {GAP, SHOW}.
- Reset values: state=GAP, counter=0, idx=NUM_DIGITS-1, shadow=0, active=0, pending=0, bcd=0, an=0, frame_start=0, load_ack=0.
- load=1: shadow<=din, pending<=1. Multiple loads before apply: last one wins, one load_ack only.
- GAP: an=0, bcd holds; counter counts 0..GAP_CYCLES-1. On terminal count: idx<=idx+1 (wraps NUM_DIGITS-1 -> 0), state<=SHOW, counter<=0.
- Frame wrap (idx NUM_DIGITS-1 -> 0): if pending, active<=shadow, pending<=0, load_ack pulses in first SHOW cycle; frame_start pulses in the same cycle regardless.
- Digit 0 of a new frame already shows the newly applied value (bcd/an computed from next-active).
- SHOW: bcd=active[4*idx+:4]; an=one-hot(idx) unless blanked; counter counts 0..DIGIT_CYCLES-1, then state<=GAP.
- Blanking: with lzb_en=1, digit i (i>0) is blanked (an bit 0, bcd still driven) when digits i..NUM_DIGITS-1 of active are all zero. Digit 0 never blanked. Blanked digits still consume full slot time.
- Nibbles 10..15 passed through unmodified (decoder renders hex).
- load in the same cycle as the frame-wrap apply: apply uses old shadow; new din captured, pending stays 1, applied next frame.
- rst_n assertion mid-frame: all registers return to reset values immediately (an=0 asynchronously).

## Timing
- Frame length = NUM_DIGITS*(DIGIT_CYCLES+GAP_CYCLES) cycles, constant.
- After rst_n release: GAP_CYCLES dark cycles, then digit 0 lit (cycle GAP_CYCLES, counting first released edge as 0).
- load to display: 1 to one-frame+GAP_CYCLES cycles; load_ack coincides with frame_start.
- an never has more than one bit set; at least GAP_CYCLES cycles of an=0 between any two lit digits.
- pending falls in the load_ack cycle; rises the cycle after load.

## Test plan
- Params N=4, DIGIT=4, GAP=1. Reset release -> cycle 1 an=0001; cycles 1-4 lit, cycle 5 an=0000, cycles 6-9 an=0010; frame_start at cycles 1, 21, 41.
- load din=0x1234 at cycle 3 -> pending=1 cycle 4; cycle 21 load_ack=1, bcd=4 an=0001; cycle 26 bcd=3; cycle 36 bcd=1 an=1000.
- lzb_en=1, active=0x0050 -> digits 3,2 an=0000 in their slots, digit1 an=0010 bcd=5, digit0 an=0001 bcd=0; active=0x0000 -> only digit 0 lit.
- Loads 0x1111 then 0x2222 in one frame -> single load_ack, displayed 0x2222; load 0x3333 on apply cycle -> pending stays 1, shown one frame later.
- rst_n low during digit 2 slot -> an=0000, bcd=0 immediately; release -> restart sequence from digit 0 with active=0.
- din=0xABCF -> bcd sequence F,C,B,A unchanged; an one-hot checked every cycle over 3 frames.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with shadow buffer
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic                    lzb_en,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    load_ack,
  output logic                    pending
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {ST_GAP, ST_SHOW} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
  logic [4*NUM_DIGITS-1:0] active, active_nx;
  logic                    pending_nx, ack_nx, fs_nx;
  logic [3:0]              bcd_nx;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    all_zero;
  logic                    blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_GAP;
      cnt         <= '0;
      idx         <= IW'(NUM_DIGITS - 1);
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      bcd         <= 4'd0;
      an          <= '0;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shadow      <= shadow_nx;
      active      <= active_nx;
      pending     <= pending_nx;
      bcd         <= bcd_nx;
      an          <= an_nx;
      frame_start <= fs_nx;
      load_ack    <= ack_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    idx_nx     = idx;
    shadow_nx  = shadow;
    active_nx  = active;
    pending_nx = pending;
    ack_nx     = 1'b0;
    fs_nx      = 1'b0;
    case (state)
      ST_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = ST_SHOW;
          if (idx == IW'(NUM_DIGITS - 1)) begin
            idx_nx = '0;
            fs_nx  = 1'b1;
            if (pending) begin
              active_nx  = shadow;
              pending_nx = 1'b0;
              ack_nx     = 1'b1;
            end
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        if (cnt == CW'(DIGIT_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = ST_GAP;
        end
      end
    endcase
    // A load coinciding with the apply lands in shadow after the old value moves to active
    if (load) begin
      shadow_nx  = din;
      pending_nx = 1'b1;
    end
  end

  // Outputs are derived from next-state values so a freshly applied frame shows at once
  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (active_nx[4*i +: 4] == 4'd0);
      zero_from[i] = all_zero;
    end
    blank  = lzb_en && (idx_nx != '0) && zero_from[idx_nx];
    bcd_nx = bcd;
    an_nx  = '0;
    if (state_nx == ST_SHOW) begin
      bcd_nx = active_nx[{idx_nx, 2'b00} +: 4];
      if (!blank)
        an_nx = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] din;
  logic        lzb_en;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_start;
  logic        load_ack;
  logic        pending;

  int cyc;
  int n_cmp;
  int n_err;
  int ack_count;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_CYCLES(4),
    .GAP_CYCLES  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .din        (din),
    .lzb_en     (lzb_en),
    .bcd        (bcd),
    .an         (an),
    .frame_start(frame_start),
    .load_ack   (load_ack),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("an_onehot", 32'($countones(an) <= 1), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ack_count = 0;
    rst_n = 1'b0; load = 1'b0; din = '0; lzb_en = 1'b0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'h0);
    chk("rst_bcd", bcd, 4'h0);
    chk("rst_pending", pending, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_ack", load_ack, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    chk("c0_an", an, 4'h0);

    for (int c = 1; c <= 172; c++) begin
      load = 1'b0;
      if (cyc == 3)   begin load = 1'b1; din = 16'h1234; end
      if (cyc == 45)  begin load = 1'b1; din = 16'h0050; end
      if (cyc == 65)  begin load = 1'b1; din = 16'h0000; end
      if (cyc == 102) begin load = 1'b1; din = 16'h1111; end
      if (cyc == 105) begin load = 1'b1; din = 16'h2222; end
      if (cyc == 130) begin load = 1'b1; din = 16'h4444; end
      if (cyc == 140) begin load = 1'b1; din = 16'h3333; end
      if (cyc == 60)  lzb_en = 1'b1;
      if (cyc == 100) lzb_en = 1'b0;
      tick();
      load = 1'b0;
      chk("frame_start", frame_start, (cyc % 20) == 1);
      if (cyc >= 101 && cyc <= 140 && load_ack) ack_count++;
      if (cyc == 1)   begin chk("c1_an", an, 4'h1); chk("c1_bcd", bcd, 4'h0); end
      if (cyc == 4)   begin chk("c4_an", an, 4'h1); chk("c4_pending", pending, 1'b1); end
      if (cyc == 5)   chk("c5_an", an, 4'h0);
      if (cyc == 6)   chk("c6_an", an, 4'h2);
      if (cyc == 9)   chk("c9_an", an, 4'h2);
      if (cyc == 10)  chk("c10_an", an, 4'h0);
      if (cyc == 20)  begin chk("c20_pending", pending, 1'b1); chk("c20_ack", load_ack, 1'b0); end
      if (cyc == 21)  begin
        chk("c21_ack", load_ack, 1'b1); chk("c21_bcd", bcd, 4'h4);
        chk("c21_an", an, 4'h1); chk("c21_pending", pending, 1'b0);
      end
      if (cyc == 26)  begin chk("c26_bcd", bcd, 4'h3); chk("c26_an", an, 4'h2); end
      if (cyc == 31)  begin chk("c31_bcd", bcd, 4'h2); chk("c31_an", an, 4'h4); end
      if (cyc == 36)  begin chk("c36_bcd", bcd, 4'h1); chk("c36_an", an, 4'h8); end
      if (cyc == 61)  begin chk("lzb_d0_an", an, 4'h1); chk("lzb_d0_bcd", bcd, 4'h0); chk("lzb_ack", load_ack, 1'b1); end
      if (cyc == 66)  begin chk("lzb_d1_an", an, 4'h2); chk("lzb_d1_bcd", bcd, 4'h5); end
      if (cyc == 71)  begin chk("lzb_d2_an", an, 4'h0); chk("lzb_d2_bcd", bcd, 4'h0); end
      if (cyc == 73)  chk("lzb_d2_mid_an", an, 4'h0);
      if (cyc == 76)  chk("lzb_d3_an", an, 4'h0);
      if (cyc == 81)  begin chk("zero_d0_an", an, 4'h1); chk("zero_ack", load_ack, 1'b1); end
      if (cyc == 86)  chk("zero_d1_an", an, 4'h0);
      if (cyc == 91)  chk("zero_d2_an", an, 4'h0);
      if (cyc == 96)  chk("zero_d3_an", an, 4'h0);
      if (cyc == 121) begin chk("multi_ack", load_ack, 1'b1); chk("multi_bcd", bcd, 4'h2); chk("multi_pending", pending, 1'b0); end
      if (cyc == 140) chk("multi_ack_count", ack_count, 1);
      if (cyc == 141) begin chk("race_ack", load_ack, 1'b1); chk("race_bcd", bcd, 4'h4); chk("race_pending", pending, 1'b1); end
      if (cyc == 161) begin chk("race2_ack", load_ack, 1'b1); chk("race2_bcd", bcd, 4'h3); chk("race2_pending", pending, 1'b0); end
      if (cyc == 166) begin chk("race2_d1_bcd", bcd, 4'h3); chk("race2_d1_an", an, 4'h2); end
      if (cyc == 172) chk("pre_rst_an", an, 4'h4);
    end

    rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 4'h0);
    chk("async_rst_bcd", bcd, 4'h0);
    chk("async_rst_pending", pending, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    for (int c = 1; c <= 61; c++) begin
      load = 1'b0;
      if (cyc == 3) begin load = 1'b1; din = 16'hABCF; end
      tick();
      load = 1'b0;
      chk("frame_start2", frame_start, (cyc % 20) == 1);
      if (cyc == 1)  begin chk("rs_an", an, 4'h1); chk("rs_bcd", bcd, 4'h0); end
      if (cyc == 21) begin chk("hex_ack", load_ack, 1'b1); chk("hex_d0", bcd, 4'hF); end
      if (cyc == 26) chk("hex_d1", bcd, 4'hC);
      if (cyc == 31) chk("hex_d2", bcd, 4'hB);
      if (cyc == 36) begin chk("hex_d3", bcd, 4'hA); chk("hex_d3_an", an, 4'h8); end
      if (cyc == 41) begin chk("hex_f3_d0", bcd, 4'hF); chk("hex_f3_ack", load_ack, 1'b0); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
